// File: rtl/vdp_pkg.sv
// Shared encodings for the VDP host port: command ops, VDP bus modes,
// VDP register indices, the bus-cycle FSM states and the command expansion list.
package vdp_pkg;

    localparam logic [1:0] OP_REG   = 2'd0;
    localparam logic [1:0] OP_VRAM  = 2'd1;
    localparam logic [1:0] OP_WADDR = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [1:0] MODE_REGADDR = 2'd0;
    localparam logic [1:0] MODE_REGDATA = 2'd1;
    localparam logic [1:0] MODE_VRAM    = 2'd2;

    localparam logic [7:0] REG_RADDR_L = 8'd0;
    localparam logic [7:0] REG_RADDR_H = 8'd1;
    localparam logic [7:0] REG_WADDR_L = 8'd2;
    localparam logic [7:0] REG_WADDR_H = 8'd3;
    localparam logic [7:0] REG_ATTR_H  = 8'd16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ASSERT,
        ST_RELEASE
    } bus_state_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] data;
    } bus_wr_t;

    // Index of the final bus write in a command's expansion list.
    function automatic logic [1:0] last_index(input logic [1:0] op);
        case (op)
            OP_REG:   last_index = 2'd1;
            OP_WADDR: last_index = 2'd3;
            default:  last_index = 2'd0;
        endcase
    endfunction

    // Bus write number idx of a command.
    function automatic bus_wr_t expand(input logic [1:0] op, input logic [1:0] idx,
                                       input logic [7:0] addr, input logic [7:0] data);
        expand = '{mode: MODE_REGADDR, data: 8'h00};
        case (op)
            OP_REG:   expand = (idx == 2'd0) ? '{mode: MODE_REGADDR, data: addr}
                                             : '{mode: MODE_REGDATA, data: data};
            OP_VRAM:  expand = '{mode: MODE_VRAM, data: data};
            OP_WADDR: begin
                case (idx)
                    2'd0:    expand = '{mode: MODE_REGADDR, data: REG_WADDR_L};
                    2'd1:    expand = '{mode: MODE_REGDATA, data: data};
                    2'd2:    expand = '{mode: MODE_REGADDR, data: REG_WADDR_H};
                    default: expand = '{mode: MODE_REGDATA, data: addr};
                endcase
            end
            default:  expand = '{mode: MODE_REGADDR, data: 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/vdp_bus_cycle.sv
// Executes one VDP bus write: SETUP, ASSERT (min width, rdy wait for VRAM,
// timeout) and RELEASE with mode/data held. A start on the last RELEASE clock chains writes.
module vdp_bus_cycle
    import vdp_pkg::*;
#(
    parameter int unsigned ASSERT_CYCLES  = 2,
    parameter int unsigned RECOVER_CYCLES = 1,
    parameter int unsigned RDY_TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] wdata,
    input  logic       vdp_rdy,
    output logic [1:0] vdp_mode,
    output logic       vdp_write,
    output logic [7:0] vdp_data,
    output logic       done_c,
    output logic       timeout_c
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] ASSERT_LAST  = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] RECOVER_LAST = CW'(RECOVER_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_MAX     = CW'(RDY_TIMEOUT);

    bus_state_t    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wait_cnt;
    logic          min_met_c;
    logic          go_c;

    // cnt saturates at ASSERT_LAST, so min_met_c stays true for the rest of ASSERT.
    assign min_met_c = (state == ST_ASSERT) && (cnt == ASSERT_LAST);
    assign go_c      = min_met_c && ((vdp_mode != MODE_VRAM) || vdp_rdy);
    assign timeout_c = min_met_c && (vdp_mode == MODE_VRAM) && !vdp_rdy && (wait_cnt == WAIT_MAX);
    assign done_c    = (state == ST_RELEASE) && (cnt == RECOVER_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wait_cnt  <= '0;
            vdp_mode  <= MODE_REGADDR;
            vdp_write <= 1'b0;
            vdp_data  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vdp_mode <= mode;
                        vdp_data <= wdata;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    vdp_write <= 1'b1;
                    cnt       <= '0;
                    wait_cnt  <= '0;
                    state     <= ST_ASSERT;
                end
                ST_ASSERT: begin
                    if (go_c || timeout_c) begin
                        vdp_write <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_RELEASE;
                    end else if (!min_met_c) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (done_c) begin
                        if (start) begin
                            vdp_mode <= mode;
                            vdp_data <= wdata;
                            state    <= ST_SETUP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vdp_host_port.sv
// Command front end for the VDP CPU port: latches a command, walks its
// expansion list through vdp_bus_cycle, and keeps the sticky err flag.
module vdp_host_port
    import vdp_pkg::*;
#(
    parameter int unsigned ASSERT_CYCLES  = 2,
    parameter int unsigned RECOVER_CYCLES = 1,
    parameter int unsigned RDY_TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       err,
    input  logic       err_clear,
    output logic [1:0] vdp_mode,
    output logic       vdp_write,
    output logic [7:0] vdp_data,
    input  logic       vdp_rdy
);

    logic [1:0] op_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [1:0] idx_q;
    logic       abort_q;

    logic       accept_c;
    logic       more_c;
    logic       next_c;
    logic       start_c;
    logic       finish_c;
    logic       bc_done_c;
    logic       bc_timeout_c;
    bus_wr_t    wr_c;

    assign accept_c = cmd_valid && cmd_ready;
    assign more_c   = (idx_q != last_index(op_q));
    assign next_c   = busy && (op_q != OP_RSVD) && bc_done_c && !abort_q && more_c;
    assign start_c  = (accept_c && (cmd_op != OP_RSVD)) || next_c;
    assign finish_c = busy && ((op_q == OP_RSVD) || (bc_done_c && (abort_q || !more_c)));
    assign wr_c     = accept_c ? expand(cmd_op, 2'd0, cmd_addr, cmd_data)
                               : expand(op_q, 2'(idx_q + 2'd1), addr_q, data_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_REG;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            idx_q     <= 2'd0;
            abort_q   <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else if (accept_c) begin
            op_q      <= cmd_op;
            addr_q    <= cmd_addr;
            data_q    <= cmd_data;
            idx_q     <= 2'd0;
            abort_q   <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
        end else if (finish_c) begin
            abort_q   <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            if (next_c) begin
                idx_q <= 2'(idx_q + 2'd1);
            end
            if (bc_timeout_c) begin
                abort_q <= 1'b1;
            end
        end
    end

    // Sticky error; a set on the same clock as err_clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (bc_timeout_c || (accept_c && (cmd_op == OP_RSVD))) begin
            err <= 1'b1;
        end else if (err_clear) begin
            err <= 1'b0;
        end
    end

    vdp_bus_cycle #(
        .ASSERT_CYCLES (ASSERT_CYCLES),
        .RECOVER_CYCLES(RECOVER_CYCLES),
        .RDY_TIMEOUT   (RDY_TIMEOUT)
    ) u_bus_cycle (
        .clk      (clk),
        .reset    (reset),
        .start    (start_c),
        .mode     (wr_c.mode),
        .wdata    (wr_c.data),
        .vdp_rdy  (vdp_rdy),
        .vdp_mode (vdp_mode),
        .vdp_write(vdp_write),
        .vdp_data (vdp_data),
        .done_c   (bc_done_c),
        .timeout_c(bc_timeout_c)
    );

endmodule

// File: tb/tb_vdp_host_port.sv
// Directed bench for vdp_host_port: stimulus pushes expected bus writes into a
// queue, a forked monitor pops and checks each write-fall and feeds a small VDP model.
module tb_vdp_host_port;
    import vdp_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic       busy;
    logic       err;
    logic       err_clear = 1'b0;
    logic [1:0] vdp_mode;
    logic       vdp_write;
    logic [7:0] vdp_data;
    logic       vdp_rdy = 1'b1;

    int checks = 0;
    int errors = 0;

    bus_wr_t    exp_q[$];
    int         last_hi = 0;
    logic [7:0] vdp_regs [0:31];
    logic [7:0] vdp_ptr = 8'h00;
    logic [7:0] vram [0:65535];

    always #5 clk = ~clk;

    vdp_host_port dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .busy     (busy),
        .err      (err),
        .err_clear(err_clear),
        .vdp_mode (vdp_mode),
        .vdp_write(vdp_write),
        .vdp_data (vdp_data),
        .vdp_rdy  (vdp_rdy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic push(input logic [1:0] m, input logic [7:0] d);
        exp_q.push_back('{mode: m, data: d});
    endtask

    // Handles one falling edge of vdp_write: scoreboard compare, then VDP model update.
    task automatic on_fall(input int hi);
        bus_wr_t e;
        logic [15:0] wa;
        last_hi = hi;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got mode %0d data %0h, expected no write", vdp_mode, vdp_data);
        end else begin
            e = exp_q.pop_front();
            chk("fall_mode", 32'(vdp_mode), 32'(e.mode));
            chk("fall_data", 32'(vdp_data), 32'(e.data));
            if (e.mode == MODE_VRAM) chk("vram_write_min_width", 32'(hi >= 2), 32'd1);
            else                     chk("reg_write_width", 32'(hi), 32'd2);
        end
        case (vdp_mode)
            MODE_REGADDR: vdp_ptr = vdp_data;
            MODE_REGDATA: vdp_regs[vdp_ptr[4:0]] = vdp_data;
            MODE_VRAM: begin
                wa = {vdp_regs[3], vdp_regs[2]};
                vram[wa] = vdp_data;
                wa = wa + 16'd1;
                vdp_regs[3] = wa[15:8];
                vdp_regs[2] = wa[7:0];
            end
            default: ;
        endcase
    endtask

    task automatic monitor();
        bit prev_w = 1'b0;
        int hi = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_w = 1'b0;
                hi = 0;
            end else begin
                if (vdp_write) hi++;
                else begin
                    if (prev_w) on_fall(hi);
                    hi = 0;
                end
                prev_w = vdp_write;
            end
        end
    endtask

    // Offers one command; returns on the negedge after the accepting posedge.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("send_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_op = op;
        cmd_addr = a;
        cmd_data = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Clocks from accept until cmd_ready is seen high again.
    task automatic wait_idle(output int n);
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("idle_timeout", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        for (int i = 0; i < 32; i++) vdp_regs[i] = 8'h00;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_write", 32'(vdp_write), 32'd0);
        chk("rst_mode", 32'(vdp_mode), 32'd0);
        chk("rst_data", 32'(vdp_data), 32'd0);

        // REG 4 <= 0x50: two writes of 1+2+1 clocks each.
        push(MODE_REGADDR, 8'h04);
        push(MODE_REGDATA, 8'h50);
        send(OP_REG, 8'h04, 8'h50);
        chk("reg_busy", 32'(busy), 32'd1);
        wait_idle(lat);
        chk("reg_latency", 32'(lat), 32'd8);
        chk("reg_model", 32'(vdp_regs[4]), 32'h50);

        // WADDR 0x1234 expands to (0,2),(1,34),(0,3),(1,12).
        push(MODE_REGADDR, 8'h02);
        push(MODE_REGDATA, 8'h34);
        push(MODE_REGADDR, 8'h03);
        push(MODE_REGDATA, 8'h12);
        send(OP_WADDR, 8'h12, 8'h34);
        wait_idle(lat);
        chk("waddr_latency", 32'(lat), 32'd16);
        chk("waddr_model", 32'({vdp_regs[3], vdp_regs[2]}), 32'h1234);

        // Three back-to-back VRAM bytes with rdy already high.
        push(MODE_VRAM, 8'hAA);
        send(OP_VRAM, 8'h00, 8'hAA);
        wait_idle(lat);
        chk("vram_latency", 32'(lat), 32'd4);
        push(MODE_VRAM, 8'hBB);
        send(OP_VRAM, 8'h00, 8'hBB);
        wait_idle(lat);
        push(MODE_VRAM, 8'hCC);
        send(OP_VRAM, 8'h00, 8'hCC);
        wait_idle(lat);
        chk("vram_1234", 32'(vram[16'h1234]), 32'hAA);
        chk("vram_1235", 32'(vram[16'h1235]), 32'hBB);
        chk("vram_1236", 32'(vram[16'h1236]), 32'hCC);

        // rdy low for the first 10 clocks of write: release the clock after rdy is seen.
        vdp_rdy = 1'b0;
        push(MODE_VRAM, 8'hDD);
        send(OP_VRAM, 8'h00, 8'hDD);
        k = 0;
        while (!vdp_write && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (9) @(negedge clk);
        vdp_rdy = 1'b1;
        wait_idle(lat);
        chk("rdy_wait_width", 32'(last_hi), 32'd10);
        chk("rdy_wait_err", 32'(err), 32'd0);
        chk("vram_1237", 32'(vram[16'h1237]), 32'hDD);

        // rdy stuck low: 1 setup + 2 assert + 255 tolerated waits, abort on the next clock.
        vdp_rdy = 1'b0;
        push(MODE_VRAM, 8'hEE);
        send(OP_VRAM, 8'h00, 8'hEE);
        k = 0;
        while (!err && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_clocks", 32'(k), 32'd258);
        chk("timeout_write_low", 32'(vdp_write), 32'd0);
        wait_idle(lat);
        chk("timeout_idle_busy", 32'(busy), 32'd0);
        vdp_rdy = 1'b1;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        // Reserved op with err_clear on the same clock: set wins, no bus activity.
        err_clear = 1'b1;
        send(OP_RSVD, 8'h00, 8'h00);
        err_clear = 1'b0;
        chk("rsvd_err_set_wins", 32'(err), 32'd1);
        chk("rsvd_no_write", 32'(vdp_write), 32'd0);
        wait_idle(lat);
        chk("rsvd_latency", 32'(lat), 32'd1);
        repeat (3) @(negedge clk);

        // Reset during the first ASSERT of a WADDR command (err still set).
        send(OP_WADDR, 8'h56, 8'h78);
        k = 0;
        while (!vdp_write && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_assert_write", 32'(vdp_write), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_write", 32'(vdp_write), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Normal operation resumes after the aborted command.
        push(MODE_REGADDR, 8'h05);
        push(MODE_REGDATA, 8'h77);
        send(OP_REG, 8'h05, 8'h77);
        wait_idle(lat);
        chk("post_rst_latency", 32'(lat), 32'd8);
        chk("post_rst_model", 32'(vdp_regs[5]), 32'h77);
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vdp_host_port.md
Name: vdp_host_port

Overview:
- Bus initiator that drives the VDP's CPU-side port (mode, write, data_in, rdy) on behalf of a simple command stream.
- Used by the boot-time register loader and a DMA-style VRAM filler.
- Converts each command into one or more VDP bus writes, respecting write-pulse timing and the rdy back-pressure on VRAM writes.
- Sits between the command source and the VDP; same clock as the VDP.

Parameters:
- ASSERT_CYCLES, 2, minimum clocks `write` is held high per bus write (≥1).
- RECOVER_CYCLES, 1, clocks `write` is held low after each bus write, with mode/data held stable (≥1).
- RDY_TIMEOUT, 255, maximum clocks spent waiting for rdy during a mode-2 write before error abort (8-bit counter).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  0=REG, 1=VRAM, 2=WADDR, 3=reserved
- cmd_addr  in  8  REG: register index; WADDR: address high byte
- cmd_data  in  8  REG: value; VRAM: byte; WADDR: address low byte
- busy  out  1  command in progress
- err  out  1  sticky error flag: timeout or reserved op
- err_clear  in  1  clears err
- vdp_mode  out  2  to VDP mode
- vdp_write  out  1  to VDP write
- vdp_data  out  8  to VDP data_in
- vdp_rdy  in  1  from VDP rdy

Behaviour:
- Reset: cmd_ready=1, busy=0, err=0, vdp_write=0, vdp_mode=0, vdp_data=0, FSM=IDLE, all counters 0.
- Reset mid-operation aborts immediately. The VDP sees write fall with whatever mode is on the bus; this is acceptable because the VDP is reset by the same reset.
- Command latched in IDLE on cmd_valid&cmd_ready. cmd_ready=1 only in IDLE.
- Command expands into a list of bus writes (mode, byte):
  - REG: (0,cmd_addr), (1,cmd_data).
  - VRAM: (2,cmd_data).
  - WADDR: (0,2), (1,cmd_data), (0,3), (1,cmd_addr).
  - op 3: no bus activity; sets err; returns to IDLE next clock.
- FSM: IDLE -> SETUP -> ASSERT -> RELEASE -> (SETUP for next write | IDLE).
  - SETUP (1 clk): vdp_mode/vdp_data driven, vdp_write=0.
  - ASSERT: vdp_write=1. Leave after ASSERT_CYCLES clocks if mode≠2. If mode=2, also require vdp_rdy=1 sampled on a clock at least ASSERT_CYCLES after entry.
  - RELEASE: vdp_write=0, mode/data unchanged for RECOVER_CYCLES clocks. The falling edge with mode=2 held is what triggers the VDP VRAM write, so mode must not change on the fall cycle.
- Timeout: in ASSERT with mode=2, if wait exceeds RDY_TIMEOUT clocks → set err, go to RELEASE, drop remaining writes, return to IDLE.
- Latency: REG with defaults = 2×(1+2+1) = 8 clocks from accept to IDLE. VRAM with rdy already high = 4 clocks.
- err: set by timeout or op 3. Cleared by err_clear. If set and clear occur on the same clock, set wins.
- A write counter indexes the expansion list (2 bits). The wait counter saturates at RDY_TIMEOUT.
- vdp_data/vdp_mode are registered outputs only; no combinational path from cmd_* to vdp_*.

Decomposition:
- Shared package vdp_pkg:
  - op encodings (OP_REG, OP_VRAM, OP_WADDR, OP_RSVD);
  - VDP mode encodings (MODE_REGADDR=0, MODE_REGDATA=1, MODE_VRAM=2);
  - VDP register indices (REG_RADDR_L=0 … REG_ATTR_H=16);
  - FSM state enum.
- One sub-module, vdp_bus_cycle: executes one (mode, byte) write with the SETUP/ASSERT/RELEASE timing, rdy wait and timeout; reports done/timeout.
- vdp_host_port holds the command latch, expansion list and err.

Test Plan:
- REG op 4, data 0x50 → bus writes (0,0x04) then (1,0x50); vdp_write high exactly 2 clocks each; cmd_ready back high 8 clocks after accept.
- WADDR addr_hi=0x12, lo=0x34 → sequence (0,2),(1,0x34),(0,3),(1,0x12); VDP model write_address=0x1234.
- Three back-to-back VRAM bytes 0xAA,0xBB,0xCC against the VDP model → VRAM 0x1234..0x1236 hold AA,BB,CC; vdp_mode=2 on every write-fall cycle.
- VRAM write with vdp_rdy forced low 10 clocks → write stays high 10+ clocks, releases the clock after rdy sampled high, err stays 0.
- vdp_rdy stuck low → err=1 after 255 wait clocks, FSM returns to IDLE; err_clear → err=0. Op 3 → err=1, no vdp_write activity.
- Reset asserted during ASSERT of a WADDR command → next clock vdp_write=0, cmd_ready=1, busy=0, err=0.
